// File: rtl/srlz_pkg.sv
// Shared definitions for the serial link: framing FSM states, default word
// width, and the counter-width helper used by serializer and deserializer.
package srlz_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } srlz_state_e;

    localparam int DEF_DATA_WIDTH = 8;

    // Width of a bit counter spanning 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/deserializer_sipo_if.sv
// Serial input stream plus parallel valid/ready output bundle of the SIPO
// deserializer. master = upstream/downstream side, slave = deserializer.
interface deserializer_sipo_if #(
    parameter int DATA_WIDTH = srlz_pkg::DEF_DATA_WIDTH
);
    logic                  srl_in;
    logic                  shift;
    logic                  frame_start;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  overrun;
    logic                  sync_err;
    logic                  locked;

    modport master (
        output srl_in, shift, frame_start, data_ready,
        input  data_out, data_valid, overrun, sync_err, locked
    );

    modport slave (
        input  srl_in, shift, frame_start, data_ready,
        output data_out, data_valid, overrun, sync_err, locked
    );
endinterface

// File: rtl/deserializer_sipo.sv
// Serial-in/parallel-out deserializer: locks onto word boundaries with a
// frame-start marker, reassembles DATA_WIDTH-bit words and presents them over
// a valid/ready handshake with overrun and resync pulses.
module deserializer_sipo
    import srlz_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    deserializer_sipo_if.slave bus
);

    localparam int            CW   = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    srlz_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  sync_err_q, sync_err_d;

    // Register position of the bit with stream index c (mirrored for MSB-first).
    function automatic logic [CW-1:0] bit_pos(input logic [CW-1:0] c);
        return MSB_FIRST ? (LAST - c) : c;
    endfunction

    // State register: framing FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the first qualified frame_start acquires lock, which is
    // only lost on reset.
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && bus.shift && bus.frame_start) begin
            state_d = LOCKED;
        end
    end

    // Output/datapath logic: bit capture, word completion, handshake, pulses.
    // A frame_start at cnt=0 while locked is an ordinary bit 0, so it shares the
    // normal capture path; only a mid-word frame_start takes the resync branch.
    always_comb begin
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        valid_d    = valid_q & ~bus.data_ready;
        overrun_d  = 1'b0;
        sync_err_d = 1'b0;
        if (bus.shift) begin
            if (state_q == IDLE) begin
                if (bus.frame_start) begin
                    sreg_d[bit_pos('0)] = bus.srl_in;
                    cnt_d               = CW'(1);
                end
            end else if (bus.frame_start && cnt_q != '0) begin
                sreg_d[bit_pos('0)] = bus.srl_in;
                cnt_d               = CW'(1);
                sync_err_d          = 1'b1;
            end else begin
                sreg_d[bit_pos(cnt_q)] = bus.srl_in;
                if (cnt_q == LAST) begin
                    cnt_d     = '0;
                    dout_d    = sreg_d;
                    valid_d   = 1'b1;
                    overrun_d = valid_q & ~bus.data_ready;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q     <= '0;
            cnt_q      <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.locked     = (state_q == LOCKED);

endmodule
